sensor_copy_sched: RTL and testbench

//  Sequences the sensor controller: enables sampling, waits for its buffer-full interrupt,

---
 rtl/sensor_copy_sched.sv | 203 ++++++++++++++++++++
 tb/tb_sensor_copy_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_copy_sched.sv
// Sensor controller sequencer: arms sampling, copies a full DEPTH-word buffer to memory, clears, re-arms.
// Optional build macro SCOPY_CHECKSUM_EN turns cfg reg 3 into a per-frame data checksum instead of FRAME_CNT.
module sensor_copy_sched #(
   parameter int DEPTH = 64,
   parameter int IW    = 6
) (
   input  logic          ACLK,
   input  logic          ARESETn,
   input  logic          sctrl_interrupt,
   input  logic [31:0]   sctrl_out,
   output logic          sctrl_en,
   output logic          sctrl_clear,
   output logic [IW-1:0] sctrl_addr,
   output logic          wr_valid,
   output logic [31:0]   wr_addr,
   output logic [31:0]   wr_data,
   input  logic          wr_ready,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_addr,
   input  logic [31:0]   cfg_wdata,
   output logic [31:0]   cfg_rdata,
   output logic          irq_o
);

`ifdef SCOPY_CHECKSUM_EN
   localparam bit CKSUM_EN = 1'b1;
`else
   localparam bit CKSUM_EN = 1'b0;
`endif

   localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SENSE = 3'd1,
      S_READ  = 3'd2,
      S_WRITE = 3'd3,
      S_CLEAR = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [31:0]   data_q, data_d;
   logic          enable_q, enable_d;
   logic          irq_en_q, irq_en_d;
   logic [31:0]   dst_base_q, dst_base_d;
   logic          done_q, done_d;
   logic [31:0]   reg3_q, reg3_d;
   logic          busy_s;

   assign busy_s     = (state_q == S_READ) || (state_q == S_WRITE) ||
                       (state_q == S_CLEAR) || (state_q == S_DONE);
   assign sctrl_addr = idx_q;
   assign irq_o      = done_q & irq_en_q;

   // Next-state, cfg register updates and FSM-decoded outputs
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      data_d      = data_q;
      enable_d    = enable_q;
      irq_en_d    = irq_en_q;
      dst_base_d  = dst_base_q;
      done_d      = done_q;
      reg3_d      = reg3_q;
      sctrl_en    = 1'b0;
      sctrl_clear = 1'b0;
      wr_valid    = 1'b0;
      wr_addr     = 32'h0000_0000;
      wr_data     = 32'h0000_0000;

      // cfg writes first so a DONE-cycle set of done overrides a simultaneous W1C
      if (cfg_we) begin
         case (cfg_addr)
            2'd0: begin
               enable_d = cfg_wdata[0];
               irq_en_d = cfg_wdata[1];
            end
            2'd1: dst_base_d = cfg_wdata;
            2'd2: begin
               if (cfg_wdata[1]) begin
                  done_d = 1'b0;
               end else begin
                  done_d = done_q;
               end
            end
            default: reg3_d = reg3_q;
         endcase
      end else begin
         done_d = done_q;
      end

      case (state_q)
         S_IDLE: begin
            if (enable_q) begin
               state_d = S_SENSE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SENSE: begin
            sctrl_en = 1'b1;
            if (!enable_q) begin
               state_d = S_IDLE;
            end else if (sctrl_interrupt) begin
               state_d = S_READ;
               idx_d   = {IW{1'b0}};
               if (CKSUM_EN) begin
                  reg3_d = 32'h0000_0000;
               end else begin
                  reg3_d = reg3_q;
               end
            end else begin
               state_d = S_SENSE;
            end
         end
         S_READ: begin
            sctrl_en = 1'b1;
            data_d   = sctrl_out;
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            sctrl_en = 1'b1;
            wr_valid = 1'b1;
            wr_addr  = dst_base_q + {{(30 - IW){1'b0}}, idx_q, 2'b00};
            wr_data  = data_q;
            if (wr_ready) begin
               if (CKSUM_EN) begin
                  reg3_d = reg3_q + data_q;
               end else begin
                  reg3_d = reg3_q;
               end
               if (idx_q == IDX_LAST) begin
                  state_d = S_CLEAR;
               end else begin
                  idx_d   = idx_q + IDX_ONE;
                  state_d = S_READ;
               end
            end else begin
               state_d = S_WRITE;
            end
         end
         S_CLEAR: begin
            sctrl_clear = 1'b1;
            if (!sctrl_interrupt) begin
               state_d = S_DONE;
            end else begin
               state_d = S_CLEAR;
            end
         end
         S_DONE: begin
            done_d = 1'b1;
            if (CKSUM_EN) begin
               reg3_d = reg3_q;
            end else begin
               reg3_d = reg3_q + 32'd1;
            end
            if (enable_q) begin
               state_d = S_SENSE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Register read mux
   always_comb begin
      case (cfg_addr)
         2'd0:    cfg_rdata = {30'h0, irq_en_q, enable_q};
         2'd1:    cfg_rdata = dst_base_q;
         2'd2:    cfg_rdata = {30'h0, done_q, busy_s};
         default: cfg_rdata = reg3_q;
      endcase
   end

   // State and register file
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q    <= S_IDLE;
         idx_q      <= {IW{1'b0}};
         data_q     <= 32'h0000_0000;
         enable_q   <= 1'b0;
         irq_en_q   <= 1'b0;
         dst_base_q <= 32'h0000_0000;
         done_q     <= 1'b0;
         reg3_q     <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         enable_q   <= enable_d;
         irq_en_q   <= irq_en_d;
         dst_base_q <= dst_base_d;
         done_q     <= done_d;
         reg3_q     <= reg3_d;
      end
   end

endmodule

// File: tb/tb_sensor_copy_sched.sv
// Self-checking bench for sensor_copy_sched: a write scoreboard built from the frame rules
// (address = base + 4*k, word k = k+1+salt) plus directed scenarios with literal expectations.
module tb_sensor_copy_sched;
   localparam int DEPTH = 64;
   localparam int IW    = 6;
`ifdef SCOPY_CHECKSUM_EN
   localparam bit USE_CKS = 1'b1;
`else
   localparam bit USE_CKS = 1'b0;
`endif

   logic          ACLK;
   logic          ARESETn;
   logic          sctrl_interrupt;
   logic [31:0]   sctrl_out;
   logic          sctrl_en;
   logic          sctrl_clear;
   logic [IW-1:0] sctrl_addr;
   logic          wr_valid;
   logic [31:0]   wr_addr;
   logic [31:0]   wr_data;
   logic          wr_ready;
   logic          cfg_we;
   logic [1:0]    cfg_addr;
   logic [31:0]   cfg_wdata;
   logic [31:0]   cfg_rdata;
   logic          irq_o;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] salt = 32'd0;
   logic [31:0] exp_base = 32'd0;
   int          exp_k = 0;
   int          writes_seen = 0;
   int          present_cnt = 0;
   int          max_present = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr = 32'd0;
   logic [31:0] prev_data = 32'd0;
   logic [31:0] last_data = 32'd0;
   logic [31:0] frame_addr [DEPTH];

   sensor_copy_sched #(.DEPTH(DEPTH), .IW(IW)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .sctrl_interrupt(sctrl_interrupt), .sctrl_out(sctrl_out),
      .sctrl_en(sctrl_en), .sctrl_clear(sctrl_clear), .sctrl_addr(sctrl_addr),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
      .irq_o(irq_o)
   );

   // Sensor buffer model: word i holds i+1+salt
   assign sctrl_out = 32'(sctrl_addr) + 32'd1 + salt;

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_reg3(input int frames, input logic [31:0] s);
      logic [31:0] sum;
      logic [31:0] cnt;
      sum = 32'd2080 + 32'd64 * s;
      cnt = 32'(frames);
      return USE_CKS ? sum : cnt;
   endfunction

   // Scoreboard: every accepted write must be the next word of the frame; stalled requests must hold
   always @(negedge ACLK) begin
      if (!ARESETn) begin
         exp_k       = 0;
         prev_stall  = 1'b0;
         present_cnt = 0;
      end else begin
         chk("en_clear_exclusive", 32'(sctrl_en & sctrl_clear), 32'd0);
         if (prev_stall) begin
            chk("hold_valid", 32'(wr_valid), 32'd1);
            chk("hold_addr", wr_addr, prev_addr);
            chk("hold_data", wr_data, prev_data);
         end
         if (wr_valid) begin
            chk("valid_implies_en", 32'(sctrl_en), 32'd1);
            present_cnt++;
            if (wr_ready) begin
               chk("wr_addr", wr_addr, exp_base + 32'(exp_k) * 32'd4);
               chk("wr_data", wr_data, 32'(exp_k) + 32'd1 + salt);
               frame_addr[exp_k] = wr_addr;
               last_data = wr_data;
               if (present_cnt > max_present) max_present = present_cnt;
               present_cnt = 0;
               exp_k = (exp_k + 1) % DEPTH;
               writes_seen++;
               prev_stall = 1'b0;
            end else begin
               prev_stall = 1'b1;
               prev_addr  = wr_addr;
               prev_data  = wr_data;
            end
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(posedge ACLK);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
      cfg_addr = a;
      #1;
      d = cfg_rdata;
   endtask

   // Drives one frame: interrupt high until the first write (or clr_hold CLEAR cycles), optional
   // stall on one word, optional disable after dis_word writes, optional W1C during DONE.
   task automatic run_frame(input int stall_word, input int stall_len, input int dis_word,
                            input int clr_hold, input bit w1c_done,
                            output int busy_cnt, output int clear_cnt, output int nwr);
      int   start;
      int   stalls;
      bit   seen;
      bit   dis_done;
      bit   fin;
      logic busy;
      start = writes_seen;
      stalls = 0; seen = 1'b0; dis_done = 1'b0; fin = 1'b0;
      busy_cnt = 0; clear_cnt = 0;
      sctrl_interrupt = 1'b1;
      wr_ready = 1'b1;
      for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
         @(posedge ACLK);
         #1;
         cfg_we   = 1'b0;
         cfg_addr = 2'd2;
         #1;
         busy = cfg_rdata[0];
         if (busy) begin
            seen = 1'b1;
            busy_cnt++;
         end else if (seen) begin
            fin = 1'b1;
         end
         if (sctrl_clear) clear_cnt++;
         if (wr_valid && wr_addr == exp_base + 32'(4 * stall_word) && stalls < stall_len) begin
            wr_ready = 1'b0;
            stalls++;
         end else begin
            wr_ready = 1'b1;
         end
         if (writes_seen - start >= 1 && clear_cnt >= clr_hold) sctrl_interrupt = 1'b0;
         if (!dis_done && writes_seen - start == dis_word) begin
            cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'd0;
            dis_done = 1'b1;
         end
         if (w1c_done && busy && !sctrl_clear && clear_cnt > 0) begin
            cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h2;
         end
      end
      cfg_we = 1'b0;
      wr_ready = 1'b1;
      nwr = writes_seen - start;
      chk("frame_finished", 32'(fin), 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      int          busy_cnt;
      int          clear_cnt;
      int          nwr;
      bit          found;

      ARESETn = 1'b0; sctrl_interrupt = 1'b0; wr_ready = 1'b0;
      cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
      #12;
      chk("rst_sctrl_en", 32'(sctrl_en), 32'd0);
      chk("rst_sctrl_clear", 32'(sctrl_clear), 32'd0);
      chk("rst_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_irq", 32'(irq_o), 32'd0);
      for (int a = 0; a < 4; a++) begin
         cfg_read(2'(a), rd);
         chk("rst_reg", rd, 32'd0);
      end
      @(posedge ACLK); #1;
      ARESETn = 1'b1;

      // Basic frame to 0x2000, data 1..64
      exp_base = 32'h2000; salt = 32'd0;
      cfg_write(2'd1, 32'h2000);
      cfg_read(2'd1, rd); chk("dst_base_rd", rd, 32'h2000);
      cfg_write(2'd0, 32'd1);
      cfg_read(2'd0, rd); chk("ctrl_rd", rd, 32'd1);
      run_frame(-1, 0, -1, 0, 1'b0, busy_cnt, clear_cnt, nwr);
      chk("f1_writes", 32'(nwr), 32'd64);
      chk("f1_latency", 32'(busy_cnt), 32'd130);
      chk("f1_first_addr", frame_addr[0], 32'h2000);
      chk("f1_last_addr", frame_addr[63], 32'h20FC);
      chk("f1_last_data", last_data, 32'd64);
      cfg_read(2'd3, rd); chk("f1_reg3", rd, exp_reg3(1, 32'd0));
      cfg_read(2'd2, rd); chk("f1_status", rd, 32'h2);
      chk("f1_sense_en", 32'(sctrl_en), 32'd1);
      chk("f1_irq_off", 32'(irq_o), 32'd0);
      cfg_write(2'd3, 32'hFFFF_FFFF);
      cfg_read(2'd3, rd); chk("reg3_ro", rd, exp_reg3(1, 32'd0));
      cfg_write(2'd2, 32'hFFFF_FFFD);
      cfg_read(2'd2, rd); chk("status_ro_bits", rd, 32'h2);

      // Stall word 5 for three cycles
      cfg_write(2'd2, 32'h2);
      cfg_read(2'd2, rd); chk("w1c_done", rd, 32'h0);
      salt = 32'd100; max_present = 0;
      run_frame(5, 3, -1, 0, 1'b0, busy_cnt, clear_cnt, nwr);
      chk("f2_writes", 32'(nwr), 32'd64);
      chk("f2_hold_cycles", 32'(max_present), 32'd4);
      chk("f2_latency", 32'(busy_cnt), 32'd133);
      cfg_read(2'd3, rd); chk("f2_reg3", rd, exp_reg3(2, 32'd100));

      // Disable during word 10, interrupt held through three CLEAR cycles
      cfg_write(2'd2, 32'h2);
      salt = 32'd7;
      run_frame(-1, 0, 10, 3, 1'b0, busy_cnt, clear_cnt, nwr);
      chk("f3_writes", 32'(nwr), 32'd64);
      chk("f3_clear_cycles", 32'(clear_cnt), 32'd3);
      chk("f3_latency", 32'(busy_cnt), 32'd132);
      cfg_read(2'd0, rd); chk("f3_ctrl", rd, 32'd0);
      cfg_read(2'd3, rd); chk("f3_reg3", rd, exp_reg3(3, 32'd7));
      sctrl_interrupt = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge ACLK); #2;
         chk("f3_idle_en", 32'(sctrl_en), 32'd0);
         cfg_read(2'd2, rd); chk("f3_idle_busy", rd, 32'h2);
      end
      sctrl_interrupt = 1'b0;

      // W1C in the DONE cycle: set wins, irq stays up; later W1C drops it next cycle
      cfg_write(2'd2, 32'h2);
      cfg_write(2'd0, 32'd3);
      chk("f4_irq_pre", 32'(irq_o), 32'd0);
      salt = 32'h55;
      run_frame(-1, 0, -1, 0, 1'b1, busy_cnt, clear_cnt, nwr);
      chk("f4_writes", 32'(nwr), 32'd64);
      cfg_read(2'd2, rd); chk("f4_done_wins", rd, 32'h2);
      chk("f4_irq_on", 32'(irq_o), 32'd1);
      cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h2;
      #1;
      chk("f4_irq_before_w1c", 32'(irq_o), 32'd1);
      @(posedge ACLK); #1;
      cfg_we = 1'b0;
      chk("f4_irq_after_w1c", 32'(irq_o), 32'd0);

      // Address wrap at the top of the 32-bit space
      exp_base = 32'hFFFF_FFF0; salt = 32'd0;
      cfg_write(2'd1, 32'hFFFF_FFF0);
      run_frame(-1, 0, -1, 0, 1'b0, busy_cnt, clear_cnt, nwr);
      chk("f5_writes", 32'(nwr), 32'd64);
      chk("f5_addr3", frame_addr[3], 32'hFFFF_FFFC);
      chk("f5_addr4_wrap", frame_addr[4], 32'h0000_0000);
      chk("f5_addr63", frame_addr[63], 32'h0000_00EC);
      cfg_read(2'd3, rd); chk("f5_reg3", rd, exp_reg3(5, 32'd0));
      chk("f5_irq", 32'(irq_o), 32'd1);

      // Reset in the middle of a write
      sctrl_interrupt = 1'b1; wr_ready = 1'b0; found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(posedge ACLK); #2;
         if (wr_valid) found = 1'b1;
      end
      chk("rst_reached_write", 32'(found), 32'd1);
      ARESETn = 1'b0;
      #1;
      chk("arst_wr_valid", 32'(wr_valid), 32'd0);
      chk("arst_wr_addr", wr_addr, 32'd0);
      chk("arst_wr_data", wr_data, 32'd0);
      chk("arst_sctrl_en", 32'(sctrl_en), 32'd0);
      chk("arst_sctrl_clear", 32'(sctrl_clear), 32'd0);
      chk("arst_sctrl_addr", 32'(sctrl_addr), 32'd0);
      chk("arst_irq", 32'(irq_o), 32'd0);
      @(posedge ACLK); #1;
      ARESETn = 1'b1; wr_ready = 1'b1;
      repeat (2) @(posedge ACLK);
      #2;
      chk("post_rst_en", 32'(sctrl_en), 32'd0);
      chk("post_rst_valid", 32'(wr_valid), 32'd0);
      cfg_read(2'd3, rd); chk("post_rst_reg3", rd, 32'd0);
      cfg_read(2'd2, rd); chk("post_rst_status", rd, 32'd0);
      cfg_read(2'd0, rd); chk("post_rst_ctrl", rd, 32'd0);
      sctrl_interrupt = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
